// File: rtl/rotor_stepper_n.sv
// rotor_stepper_n: parametrised Enigma rotor-position engine with multi-notch stepping and LIFO undo.
// Latency: a command is accepted in one cycle, then runs one step or undo per cycle; done is registered with the last operation.
// Backpressure: cmd_ready is high only while idle with no load pending; load aborts any running command.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   load, pos_load     load start positions (rotor i at [i*POS_W +: POS_W]), clear history, abort command
//   notch_mask         bit [i*ALPHA+p] marks a notch of stepping rotor i at position p
//   cmd_valid/ready    command handshake; cmd_dir 0 = step, 1 = undo; cmd_count = number of operations
//   pos                registered rotor positions
//   busy, done         command running / one-cycle completion pulse
//   err_underflow      one-cycle pulse when an undo finds the history empty
//   hist_count         number of valid history entries
module rotor_stepper_n #(
  parameter int NUM_ROTORS = 4,
  parameter int NUM_STEP   = 3,
  parameter int ALPHA      = 26,
  parameter int POS_W      = 5,
  parameter int HIST_DEPTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [NUM_ROTORS*POS_W-1:0]   pos_load,
  input  logic [NUM_STEP*ALPHA-1:0]     notch_mask,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_dir,
  input  logic [CNT_W-1:0]              cmd_count,
  output logic [NUM_ROTORS*POS_W-1:0]   pos,
  output logic                          busy,
  output logic                          done,
  output logic                          err_underflow,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count
);

  localparam int HC_W  = $clog2(HIST_DEPTH + 1);
  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int PW    = NUM_ROTORS * POS_W;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nx;

  // Datapath state
  logic [PW-1:0]       pos_q;
  logic [NUM_STEP-1:0] hist_mem [HIST_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;      // next slot to write; newest entry sits at wr_ptr-1
  logic [HC_W-1:0]     hist_cnt;
  logic                dir_q;
  logic [CNT_W-1:0]    remaining;
  logic                done_q;
  logic                err_q;

  // FSM-derived strobes
  logic accept;
  logic do_step;
  logic do_undo;
  logic underflow_hit;
  logic hist_empty;

  // Step/undo datapath
  logic [NUM_STEP-1:0] at_notch;
  logic [NUM_STEP-1:0] step_mask;
  logic [NUM_STEP-1:0] pop_mask;
  logic [PW-1:0]       pos_fwd;
  logic [PW-1:0]       pos_bwd;
  logic [PW-1:0]       pos_sane;

  assign hist_empty = (hist_cnt == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (cmd_count != '0)) begin
            state_nx = RUN;
          end
        end
        RUN: begin
          // An undo against an empty history ends the command early.
          if (underflow_hit || (remaining == CNT_W'(1))) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and operation strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready     = (state == IDLE) && !load;
    busy          = (state == RUN);
    accept        = cmd_valid && cmd_ready;
    do_step       = (state == RUN) && !load && !dir_q;
    do_undo       = (state == RUN) && !load && dir_q && !hist_empty;
    underflow_hit = (state == RUN) && !load && dir_q && hist_empty;
  end

  // ---------------------------------------------------------------------------
  // Notch detection on the pre-step positions
  // ---------------------------------------------------------------------------
  always_comb begin
    at_notch = '0;
    for (int i = 0; i < NUM_STEP; i++) begin
      for (int p = 0; p < ALPHA; p++) begin
        if (pos_q[i*POS_W +: POS_W] == POS_W'(p)) begin
          at_notch[i] = notch_mask[i*ALPHA + p];
        end
      end
    end
  end

  // Rotor 0 always moves. A rotor moves when its right neighbour sits on a
  // notch; a middle rotor also moves when it sits on its own notch (double
  // step). The leftmost stepping rotor has no left neighbour to carry into,
  // so its own notch never matters.
  always_comb begin
    step_mask    = '0;
    step_mask[0] = 1'b1;
    for (int i = 1; i < NUM_STEP; i++) begin
      if (i < NUM_STEP - 1) begin
        step_mask[i] = at_notch[i-1] | at_notch[i];
      end else begin
        step_mask[i] = at_notch[i-1];
      end
    end
  end

  logic unused_last_notch;
  assign unused_last_notch = at_notch[NUM_STEP-1];

  // Forward positions: increment flagged rotors with wrap ALPHA-1 -> 0.
  always_comb begin
    pos_fwd = pos_q;
    for (int i = 0; i < NUM_STEP; i++) begin
      if (step_mask[i]) begin
        if (pos_q[i*POS_W +: POS_W] == POS_W'(ALPHA - 1)) begin
          pos_fwd[i*POS_W +: POS_W] = '0;
        end else begin
          pos_fwd[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] + POS_W'(1);
        end
      end
    end
  end

  // Undo positions: decrement rotors flagged by the newest history entry,
  // wrap 0 -> ALPHA-1.
  assign pop_mask = hist_mem[wr_ptr - PTR_W'(1)];

  always_comb begin
    pos_bwd = pos_q;
    for (int i = 0; i < NUM_STEP; i++) begin
      if (pop_mask[i]) begin
        if (pos_q[i*POS_W +: POS_W] == '0) begin
          pos_bwd[i*POS_W +: POS_W] = POS_W'(ALPHA - 1);
        end else begin
          pos_bwd[i*POS_W +: POS_W] = pos_q[i*POS_W +: POS_W] - POS_W'(1);
        end
      end
    end
  end

  // Out-of-alphabet load values collapse to 0. The extra compare bit keeps
  // the test correct when ALPHA == 2**POS_W.
  always_comb begin
    pos_sane = pos_load;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if ({1'b0, pos_load[i*POS_W +: POS_W]} >= (POS_W+1)'(ALPHA)) begin
        pos_sane[i*POS_W +: POS_W] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // History storage: circular buffer, oldest entry overwritten when full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_step) begin
      hist_mem[wr_ptr] <= step_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= '0;
      wr_ptr    <= '0;
      hist_cnt  <= '0;
      dir_q     <= 1'b0;
      remaining <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Pulses by default; load leaves them low, which drops any pending done.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (load) begin
        pos_q     <= pos_sane;
        wr_ptr    <= '0;
        hist_cnt  <= '0;
        remaining <= '0;
      end else begin
        if (accept) begin
          dir_q     <= cmd_dir;
          remaining <= cmd_count;
          if (cmd_count == '0) begin
            done_q <= 1'b1;
          end
        end

        if (do_step) begin
          pos_q     <= pos_fwd;
          wr_ptr    <= wr_ptr + PTR_W'(1);
          remaining <= remaining - CNT_W'(1);
          if (hist_cnt != HC_W'(HIST_DEPTH)) begin
            hist_cnt <= hist_cnt + HC_W'(1);
          end
          if (remaining == CNT_W'(1)) begin
            done_q <= 1'b1;
          end
        end

        if (do_undo) begin
          pos_q     <= pos_bwd;
          wr_ptr    <= wr_ptr - PTR_W'(1);
          hist_cnt  <= hist_cnt - HC_W'(1);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            done_q <= 1'b1;
          end
        end

        // Empty history: flag it, finish now, drop the rest of the count.
        if (underflow_hit) begin
          err_q     <= 1'b1;
          done_q    <= 1'b1;
          remaining <= '0;
        end
      end
    end
  end

  assign pos           = pos_q;
  assign done          = done_q;
  assign err_underflow = err_q;
  assign hist_count    = hist_cnt;

endmodule

// File: tb/tb_rotor_stepper_n.sv
// Directed bench for rotor_stepper_n: double step, undo, multi-notch wrap,
// history overflow, load and reset mid-command, non-stepping Greek wheel.
module tb_rotor_stepper_n;

  localparam int NR = 4;
  localparam int NS = 3;
  localparam int AL = 26;
  localparam int PWID = 5;
  localparam int HD = 4;
  localparam int CW = 8;
  localparam int PW = NR * PWID;

  logic              clk;
  logic              rst;
  logic              load;
  logic [PW-1:0]     pos_load;
  logic [NS*AL-1:0]  notch_mask;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [CW-1:0]     cmd_count;
  logic [PW-1:0]     pos;
  logic              busy;
  logic              done;
  logic              err_underflow;
  logic [$clog2(HD+1)-1:0] hist_count;

  int n_checks = 0;
  int n_fail   = 0;

  rotor_stepper_n #(
    .NUM_ROTORS(NR), .NUM_STEP(NS), .ALPHA(AL), .POS_W(PWID),
    .HIST_DEPTH(HD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .pos_load(pos_load),
    .notch_mask(notch_mask), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .pos(pos), .busy(busy),
    .done(done), .err_underflow(err_underflow), .hist_count(hist_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Positions packed as {rotor3, rotor2, rotor1, rotor0}.
  function automatic logic [PW-1:0] mkpos(input int r3, input int r2, input int r1, input int r0);
    return {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [PW-1:0] p);
    load     = 1'b1;
    pos_load = p;
    tick();
    load     = 1'b0;
  endtask

  task automatic issue(input logic dir, input int cnt);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_count = CW'(cnt);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic set_std_notches();
    notch_mask = '0;
    notch_mask[0*AL + 21] = 1'b1;   // rotor 0 (III)
    notch_mask[1*AL + 4]  = 1'b1;   // rotor 1 (II)
    notch_mask[2*AL + 16] = 1'b1;   // rotor 2 (I)
  endtask

  initial begin
    logic saw_done;
    rst       = 1'b1;
    load      = 1'b0;
    pos_load  = '0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_count = '0;
    set_std_notches();

    // Reset state
    #12;
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    check("rst_hist", 32'(hist_count), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // Double step: L,M,R = 0,3,20, rotor 3 = 7
    do_load(mkpos(7, 0, 3, 20));
    check("ds_load", 32'(pos), 32'(mkpos(7, 0, 3, 20)));
    issue(1'b0, 3);
    check("ds_busy", 32'(busy), 32'd1);
    check("ds_accept_pos", 32'(pos), 32'(mkpos(7, 0, 3, 20)));
    tick();
    check("ds_step1", 32'(pos), 32'(mkpos(7, 0, 3, 21)));
    tick();
    check("ds_step2", 32'(pos), 32'(mkpos(7, 0, 4, 22)));
    check("ds_done_early", 32'(done), 32'd0);
    tick();
    check("ds_step3", 32'(pos), 32'(mkpos(7, 1, 5, 23)));
    check("ds_done", 32'(done), 32'd1);
    check("ds_idle", 32'(busy), 32'd0);
    check("ds_hist", 32'(hist_count), 32'd3);
    tick();
    check("ds_done_pulse", 32'(done), 32'd0);

    // Undo three steps, then underflow
    issue(1'b1, 3);
    tick();
    check("un_1", 32'(pos), 32'(mkpos(7, 0, 4, 22)));
    tick();
    tick();
    check("un_3", 32'(pos), 32'(mkpos(7, 0, 3, 20)));
    check("un_hist", 32'(hist_count), 32'd0);
    check("un_done", 32'(done), 32'd1);
    issue(1'b1, 1);
    tick();
    check("uf_err", 32'(err_underflow), 32'd1);
    check("uf_done", 32'(done), 32'd1);
    check("uf_pos", 32'(pos), 32'(mkpos(7, 0, 3, 20)));
    check("uf_busy", 32'(busy), 32'd0);
    tick();
    check("uf_err_pulse", 32'(err_underflow), 32'd0);

    // Zero-count command: done next cycle, no movement
    issue(1'b0, 0);
    check("zc_done", 32'(done), 32'd1);
    check("zc_busy", 32'(busy), 32'd0);
    check("zc_pos", 32'(pos), 32'(mkpos(7, 0, 3, 20)));

    // Multi-notch rotor 0 (notches 12 and 25) and wrap
    notch_mask[0*AL + 21] = 1'b0;
    notch_mask[0*AL + 12] = 1'b1;
    notch_mask[0*AL + 25] = 1'b1;
    do_load(mkpos(0, 0, 0, 12));
    issue(1'b0, 1);
    tick();
    check("mn_notch12", 32'(pos), 32'(mkpos(0, 0, 1, 13)));
    do_load(mkpos(0, 0, 0, 25));
    issue(1'b0, 1);
    tick();
    check("mn_wrap", 32'(pos), 32'(mkpos(0, 0, 1, 0)));
    issue(1'b1, 1);
    tick();
    check("mn_undo_wrap", 32'(pos), 32'(mkpos(0, 0, 0, 25)));
    set_std_notches();

    // Out-of-alphabet load values become 0
    do_load(mkpos(31, 5, 0, 26));
    check("sane_load", 32'(pos), 32'(mkpos(0, 5, 0, 0)));

    // History overflow with depth 4
    do_load(mkpos(0, 0, 0, 0));
    issue(1'b0, 6);
    wait_done("ov_fwd_done", 10);
    check("ov_fwd_pos", 32'(pos), 32'(mkpos(0, 0, 0, 6)));
    check("ov_hist_sat", 32'(hist_count), 32'd4);
    issue(1'b1, 5);
    for (int k = 0; k < 4; k++) tick();
    check("ov_undo4_pos", 32'(pos), 32'(mkpos(0, 0, 0, 2)));
    check("ov_undo4_hist", 32'(hist_count), 32'd0);
    check("ov_undo4_busy", 32'(busy), 32'd1);
    tick();
    check("ov_uf_err", 32'(err_underflow), 32'd1);
    check("ov_uf_done", 32'(done), 32'd1);
    check("ov_uf_pos", 32'(pos), 32'(mkpos(0, 0, 0, 2)));

    // Load in the 4th busy cycle of a 10-step command
    issue(1'b0, 10);
    tick();
    tick();
    tick();
    check("ld_mid_busy", 32'(busy), 32'd1);
    load     = 1'b1;
    pos_load = mkpos(3, 2, 1, 0);
    check("ld_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    load = 1'b0;
    check("ld_pos", 32'(pos), 32'(mkpos(3, 2, 1, 0)));
    check("ld_busy", 32'(busy), 32'd0);
    check("ld_hist", 32'(hist_count), 32'd0);
    saw_done = done;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("ld_no_done", 32'(saw_done), 32'd0);
    check("ld_pos_hold", 32'(pos), 32'(mkpos(3, 2, 1, 0)));

    // Load and cmd_valid together while idle: load wins
    load      = 1'b1;
    pos_load  = mkpos(1, 1, 1, 1);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_count = 8'd5;
    #1;
    check("lc_ready", 32'(cmd_ready), 32'd0);
    tick();
    load      = 1'b0;
    cmd_valid = 1'b0;
    check("lc_busy", 32'(busy), 32'd0);
    check("lc_pos", 32'(pos), 32'(mkpos(1, 1, 1, 1)));

    // Asynchronous reset during RUN
    do_load(mkpos(5, 4, 3, 2));
    issue(1'b0, 10);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("ar_pos", 32'(pos), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_hist", 32'(hist_count), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    #1;
    rst = 1'b0;
    tick();

    // Greek wheel stays put over 30 steps
    do_load(mkpos(9, 0, 0, 0));
    issue(1'b0, 30);
    wait_done("gw_done", 40);
    check("gw_pos", 32'(pos), 32'(mkpos(9, 0, 1, 4)));
    check("gw_hist", 32'(hist_count), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rotor_stepper_n.md
Name: rotor_stepper_n

Overview:
- Parametrised rotor-position engine for the Enigma datapath.
- Supports N rotors, a configurable alphabet size, and arbitrary multi-notch rotors (e.g. Naval VI–VIII), plus non-stepping rotors (M4 Greek wheel).
- Executes multi-step forward commands over a valid/ready handshake, one step per cycle.
- Keeps a LIFO history of step masks so keystrokes can be undone exactly.

Parameters:
- NUM_ROTORS, 4, total rotors; index 0 = rightmost (fastest).
- NUM_STEP, 3, rotors 0..NUM_STEP-1 step; rotors NUM_STEP..NUM_ROTORS-1 never move. Legal range 2..NUM_ROTORS.
- ALPHA, 26, alphabet size; positions are 0..ALPHA-1.
- POS_W, 5, bits per position; requires 2^POS_W >= ALPHA.
- HIST_DEPTH, 16, undo history entries (power of 2, >= 2).
- CNT_W, 8, command step-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  load pos_load, clear history, abort any command.
- pos_load  in  NUM_ROTORS*POS_W  start positions; rotor i at bits [i*POS_W +: POS_W].
- notch_mask  in  NUM_STEP*ALPHA  bit [i*ALPHA+p] = rotor i has a notch at position p. Expected static while busy.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command acceptance.
- cmd_dir  in  1  0 = forward step, 1 = undo.
- cmd_count  in  CNT_W  number of steps or undos.
- pos  out  NUM_ROTORS*POS_W  current positions (registered).
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err_underflow  out  1  one-cycle pulse when an undo is attempted with empty history.
- hist_count  out  $clog2(HIST_DEPTH+1)  valid history entries.

Behaviour:
- Reset (async, rst=1): pos=0 for all rotors, history empty, hist_count=0, busy=0, done=0, err_underflow=0, state IDLE.
- cmd_ready = (state==IDLE) && !load. A command is accepted on a clock edge where cmd_valid && cmd_ready; cmd_dir and cmd_count are latched at that edge.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on accept with cmd_count != 0.
  - Accept with cmd_count == 0: pos unchanged, done pulses the next cycle, stay IDLE.
  - RUN applies exactly one step or undo per edge. After K operations (edges T+1..T+K, where T is the accept edge), go to IDLE.
  - done is registered with the final operation, so it is high in the cycle after edge T+K. busy=1 exactly while in RUN.
- Forward step, all notch tests on pre-step positions:
  - at_notch[i] = notch_mask[i*ALPHA+pos_i].
  - Rotor 0 always steps.
  - Rotor i (1 <= i < NUM_STEP) steps if at_notch[i-1], or if (i < NUM_STEP-1 && at_notch[i]). The second term is the generalised double-step.
  - Increment wraps ALPHA-1 -> 0.
- History: each forward step pushes its NUM_STEP-bit step mask.
  - When full, the oldest entry is overwritten (circular) and hist_count saturates at HIST_DEPTH.
- Undo: pop the newest mask and decrement each flagged rotor; decrement wraps 0 -> ALPHA-1.
  - If history is empty: no movement, err_underflow pulses, the remaining count is discarded, done pulses in the same cycle, and the FSM returns to IDLE.
- Load:
  - Highest priority below reset; valid in any state.
  - Next edge: pos <= pos_load, history cleared, state IDLE, any pending done suppressed.
  - Any loaded position >= ALPHA is stored as 0.
- Rotors >= NUM_STEP change only via load or reset.
- Simultaneous load and cmd_valid: load wins and the command is not accepted (cmd_ready=0).

Test Plan:
- Double step (rotors R=III notch 21, M=II notch 4, L=I notch 16; load L,M,R = 0,3,20), forward count 3 -> after each step 0,3,21 / 0,4,22 / 1,5,23; done one cycle after the third step; hist_count=3.
- Undo: from the end of the previous test, undo count 3 -> 0,3,20, hist_count=0; a further undo count 1 -> err_underflow=1, pos unchanged, done=1.
- Wrap and multi-notch: rotor 0 notches at 12 and 25, load R=25, M=0 -> one step gives R=0, M=1; load R=12, M=0 -> step gives R=13, M=1; undo from R=0, M=1 -> R=25, M=0.
- Overflow (HIST_DEPTH=4): 6 forward steps from all-zero, then undo 5 -> first 4 undos restore the state after step 2; the 5th pulses err_underflow; hist_count=0.
- Load mid-RUN: forward count 10 accepted, load asserted at the 4th busy cycle -> pos=pos_load on the next edge, busy=0, no done pulse, hist_count=0.
- Reset mid-RUN and Greek wheel: assert rst asynchronously during RUN -> all outputs 0 immediately; with NUM_ROTORS=4, 30 forward steps leave rotor 3 at its loaded value.
